pa_fpu_rslt_pack: RTL and testbench
===================================

// Module: pa_fpu_rslt_pack
// PURPOSE
//  Encode side of FP operand classification: builds the IEEE-754 result word for the FPU write-back path.
//  Takes a result class, sign, precision, rounding mode and raw exponent/fraction.
//  Emits the 64-bit register value: single results NaN-boxed, canonical NaN, rm-dependent overflow value.
//  Emits accrued fflags with the result.
//  Sits between FPU datapath units and the FP register-file write port.
//  Contains a 2-entry in-order result buffer with valid/ready on both sides.
// PARAMETERS
//  BOX_SINGLE  1  1: single results carry upper 32 bits all-ones; 0: upper 32 bits zero
//  DEPTH       2  result buffer entries; only value 2 is supported
// PORTS
//  forever_cpuclk  in   1   clock, all state on rising edge
//  cpurst          in   1   synchronous reset, active-high
//  in_vld          in   1   request valid
//  in_rdy          out  1   request accepted when in_vld && in_rdy
//  in_double       in   1   double-precision result
//  in_single       in   1   single-precision result
//  in_sign         in   1   result sign
//  in_class        in   3   0 NORM, 1 ZERO, 2 INF, 3 QNAN, 4 OVFL, 5 DENORM; 6,7 reserved
//  in_expn         in   11  biased exponent, NORM only; single uses [7:0]
//  in_frac         in   52  fraction; NORM/DENORM; single uses [22:0]
//  in_rm           in   3   0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
//  in_flags        in   5   {NV,DZ,OF,UF,NX} from the datapath
//  out_vld         out  1   result valid
//  out_rdy         in   1   consumer ready
//  out_result      out  64  packed register value
//  out_fflags      out  5   {NV,DZ,OF,UF,NX}
// BEHAVIOUR
//  Reset: out_vld=0, out_result=0, out_fflags=0, count=0, in_rdy=1. Buffer contents are discarded.
//  Reset mid-operation flushes both entries; the cycle after reset, no result is presented.
//  Precision: in_double has priority when both are asserted.
//  When neither precision bit is set:
//   - Result is the boxed canonical single NaN.
//   - NV is ORed into the flags.
//  Pack rules, sign s. Double fields: {s,e[10:0],f[51:0]}. Single low word: {s,e[7:0],f[22:0]}.
//   - NORM: s, in_expn, in_frac passed through.
//   - DENORM: exponent field forced to 0; fraction passed through.
//   - ZERO: exponent=0, fraction=0, sign kept.
//   - INF: exponent all-ones, fraction=0.
//   - QNAN: canonical, sign ignored. D=64'h7FF8_0000_0000_0000; S low word=32'h7FC0_0000.
//   - OVFL, rm RNE/RMM: +/-inf.
//   - OVFL, rm RTZ: +/-max-normal. D exp 11'h7FE, frac all-ones; S 8'hFE, frac all-ones.
//   - OVFL, rm RDN: s=0 -> +max; s=1 -> -inf.
//   - OVFL, rm RUP: s=0 -> +inf; s=1 -> -max.
//   - OVFL, any rm: OF and NX are ORed into the flags.
//   - Reserved class and rm 5-7: treated as QNAN, with NV ORed into the flags.
//  Single upper word: 32'hFFFF_FFFF when BOX_SINGLE=1, else 0. Applies to every single result, including NaN.
//  Flags: out_fflags = in_flags | rule-added bits. Packing never clears a datapath flag.
//  Buffer state count in {0,1,2}:
//   - in_rdy = (count!=2); it is a registered, combinationally stable function of state only.
//   - push = in_vld && in_rdy; pop = out_vld && out_rdy.
//   - count 0: push -> 1. Latency is 1 cycle: result visible the cycle after acceptance.
//   - count 1: push&&pop -> 1, new entry behind the popped one; push only -> 2; pop only -> 0.
//   - count 2: pop -> 1; push is impossible.
//  Strict FIFO order. out_vld = (count!=0).
//  out_result and out_fflags are taken from the head entry and held stable while out_vld && !out_rdy.
//  in_* sampled only on push; inputs are don't-care otherwise.
//  No combinational path from in_* to out_* or from out_rdy to in_rdy.
// TESTING
//  - Single NORM: s=1, e=8'h80, frac=23'h1, rdy=1 -> cycle+1 out_result=64'hFFFF_FFFF_C000_0001, fflags=0.
//  - OVFL double, rm=RDN: s=0 -> 64'h7FEF_FFFF_FFFF_FFFF, fflags=5'b00101.
//    Same with s=1 -> 64'hFFF0_0000_0000_0000, fflags=5'b00101.
//  - QNAN single, s=1, in_flags=NV -> 64'hFFFF_FFFF_7FC0_0000, fflags=5'b10000.
//    With BOX_SINGLE=0 -> 64'h0000_0000_7FC0_0000.
//  - Backpressure: out_rdy=0, push A,B -> in_rdy=0 after 2nd push, out_result=A held.
//    out_rdy=1 -> A then B on consecutive cycles, in_rdy=1 after A pops.
//  - Simultaneous push/pop at count=1 every cycle for 8 requests -> 8 results in order, no bubbles, count stays 1.
//  - cpurst for 1 cycle with count=2 -> next cycle out_vld=0, in_rdy=1, out_result=0; old entries never appear.

Source files
------------

// File: rtl/pa_fpu_rslt_pack.sv
// FP result packer: builds IEEE-754 register words and fflags for write-back,
// buffered through a two-entry in-order valid/ready queue.
module pa_fpu_rslt_pack #(
    parameter bit BOX_SINGLE = 1'b1,
    parameter int DEPTH      = 2
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        in_double,
    input  logic        in_single,
    input  logic        in_sign,
    input  logic [2:0]  in_class,
    input  logic [10:0] in_expn,
    input  logic [51:0] in_frac,
    input  logic [2:0]  in_rm,
    input  logic [4:0]  in_flags,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [63:0] out_result,
    output logic [4:0]  out_fflags
);

    localparam logic [2:0] C_NORM   = 3'd0;
    localparam logic [2:0] C_ZERO   = 3'd1;
    localparam logic [2:0] C_INF    = 3'd2;
    localparam logic [2:0] C_QNAN   = 3'd3;
    localparam logic [2:0] C_OVFL   = 3'd4;
    localparam logic [2:0] C_DENORM = 3'd5;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [31:0] UPPER  = BOX_SINGLE ? 32'hFFFF_FFFF : 32'h0;
    localparam logic [31:0] S_QNAN = 32'h7FC0_0000;
    localparam logic [63:0] D_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [1:0]  FULL   = 2'(DEPTH);

    typedef enum logic [2:0] {
        K_PASS,
        K_DENORM,
        K_ZERO,
        K_INF,
        K_MAX,
        K_NAN
    } kind_e;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  fflags;
    } entry_t;

    kind_e       kind;
    logic        add_nv;
    logic        add_ovf;
    logic        ovf_to_max;
    logic [63:0] dbl_word;
    logic [31:0] sgl_word;
    entry_t      pk;

    logic [1:0]  count;
    entry_t      head;
    entry_t      tail;
    logic        push;
    logic        pop;

    // Overflow saturates to max-normal whenever rounding points toward zero.
    assign ovf_to_max = (in_rm == RM_RTZ)
                      | ((in_rm == RM_RDN) & ~in_sign)
                      | ((in_rm == RM_RUP) & in_sign);

    always_comb begin
        kind    = K_NAN;
        add_nv  = 1'b0;
        add_ovf = 1'b0;
        if (in_rm > RM_RMM) begin
            add_nv = 1'b1;
        end else begin
            case (in_class)
                C_NORM:   kind = K_PASS;
                C_ZERO:   kind = K_ZERO;
                C_INF:    kind = K_INF;
                C_QNAN:   kind = K_NAN;
                C_DENORM: kind = K_DENORM;
                C_OVFL: begin
                    add_ovf = 1'b1;
                    kind    = ovf_to_max ? K_MAX : K_INF;
                end
                default:  add_nv = 1'b1;
            endcase
        end
    end

    always_comb begin
        dbl_word = D_QNAN;
        case (kind)
            K_PASS:   dbl_word = {in_sign, in_expn, in_frac};
            K_DENORM: dbl_word = {in_sign, 11'd0, in_frac};
            K_ZERO:   dbl_word = {in_sign, 63'd0};
            K_INF:    dbl_word = {in_sign, 11'h7FF, 52'd0};
            K_MAX:    dbl_word = {in_sign, 11'h7FE, {52{1'b1}}};
            default:  dbl_word = D_QNAN;
        endcase
    end

    always_comb begin
        sgl_word = S_QNAN;
        case (kind)
            K_PASS:   sgl_word = {in_sign, in_expn[7:0], in_frac[22:0]};
            K_DENORM: sgl_word = {in_sign, 8'd0, in_frac[22:0]};
            K_ZERO:   sgl_word = {in_sign, 31'd0};
            K_INF:    sgl_word = {in_sign, 8'hFF, 23'd0};
            K_MAX:    sgl_word = {in_sign, 8'hFE, {23{1'b1}}};
            default:  sgl_word = S_QNAN;
        endcase
    end

    // Double wins when both precision bits are set.
    always_comb begin
        pk.result = {UPPER, S_QNAN};
        pk.fflags = in_flags | 5'b10000;
        priority case (1'b1)
            in_double: begin
                pk.result = dbl_word;
                pk.fflags = in_flags
                          | {add_nv, 1'b0, add_ovf, 1'b0, add_ovf};
            end
            in_single: begin
                pk.result = {UPPER, sgl_word};
                pk.fflags = in_flags
                          | {add_nv, 1'b0, add_ovf, 1'b0, add_ovf};
            end
            default: begin
                pk.result = {UPPER, S_QNAN};
                pk.fflags = in_flags | 5'b10000;
            end
        endcase
    end

    assign in_rdy  = (count != FULL);
    assign out_vld = (count != 2'd0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Head always feeds the outputs; tail only fills while head is stalled.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= pk;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= pk;
                    end else if (push) begin
                        tail  <= pk;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head  <= tail;
                        count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign out_result = head.result;
    assign out_fflags = head.fflags;

endmodule

// File: tb/tb_pa_fpu_rslt_pack.sv
// Bench for pa_fpu_rslt_pack: directed cases plus random traffic
// against a rule-level model with a FIFO scoreboard, boxed and unboxed.
module tb_pa_fpu_rslt_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_vld;
    logic        in_double;
    logic        in_single;
    logic        in_sign;
    logic [2:0]  in_class;
    logic [10:0] in_expn;
    logic [51:0] in_frac;
    logic [2:0]  in_rm;
    logic [4:0]  in_flags;
    logic        out_rdy;

    logic        rdy_b, vld_b, rdy_n, vld_n;
    logic [63:0] res_b, res_n;
    logic [4:0]  ff_b, ff_n;

    pa_fpu_rslt_pack #(.BOX_SINGLE(1'b1), .DEPTH(2)) u_box (
        .forever_cpuclk(clk),
        .cpurst(rst),
        .in_vld(in_vld),
        .in_rdy(rdy_b),
        .in_double(in_double),
        .in_single(in_single),
        .in_sign(in_sign),
        .in_class(in_class),
        .in_expn(in_expn),
        .in_frac(in_frac),
        .in_rm(in_rm),
        .in_flags(in_flags),
        .out_vld(vld_b),
        .out_rdy(out_rdy),
        .out_result(res_b),
        .out_fflags(ff_b)
    );

    pa_fpu_rslt_pack #(.BOX_SINGLE(1'b0), .DEPTH(2)) u_nobox (
        .forever_cpuclk(clk),
        .cpurst(rst),
        .in_vld(in_vld),
        .in_rdy(rdy_n),
        .in_double(in_double),
        .in_single(in_single),
        .in_sign(in_sign),
        .in_class(in_class),
        .in_expn(in_expn),
        .in_frac(in_frac),
        .in_rm(in_rm),
        .in_flags(in_flags),
        .out_vld(vld_n),
        .out_rdy(out_rdy),
        .out_result(res_n),
        .out_fflags(ff_n)
    );

    typedef struct {
        logic [63:0] rb;
        logic [63:0] rn;
        logic [4:0]  fl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result and flags straight from the packing rules.
    function automatic logic [68:0] ref_pack(
        input logic dbl, input logic sgl, input logic s,
        input logic [2:0] cls, input logic [2:0] rm,
        input logic [10:0] e, input logic [51:0] f,
        input logic [4:0] fl, input bit box);
        logic [31:0] hi;
        logic [4:0]  x;
        logic [63:0] d;
        logic [31:0] w;
        int          c;
        bit          to_max;
        hi = box ? 32'hFFFF_FFFF : 32'h0;
        if (!dbl && !sgl)
            return {hi, 32'h7FC0_0000, fl | 5'b10000};
        x = fl;
        c = int'(cls);
        if (rm > 3'd4 || cls > 3'd5) begin
            c = 3;
            x = x | 5'b10000;
        end
        if (c == 4) begin
            x = x | 5'b00101;
            to_max = (rm == 3'd1) || (rm == 3'd2 && !s)
                  || (rm == 3'd3 && s);
            c = to_max ? 6 : 2;
        end
        if (dbl) begin
            case (c)
                0:       d = {s, e, f};
                1:       d = {s, 63'd0};
                2:       d = {s, 63'h7FF0_0000_0000_0000};
                3:       d = 64'h7FF8_0000_0000_0000;
                5:       d = {s, 11'd0, f};
                default: d = {s, 63'h7FEF_FFFF_FFFF_FFFF};
            endcase
            return {d, x};
        end
        case (c)
            0:       w = {s, e[7:0], f[22:0]};
            1:       w = {s, 31'd0};
            2:       w = {s, 31'h7F80_0000};
            3:       w = 32'h7FC0_0000;
            5:       w = {s, 8'd0, f[22:0]};
            default: w = {s, 31'h7F7F_FFFF};
        endcase
        return {hi, w, x};
    endfunction

    task automatic observe();
        check("in_rdy_b", rdy_b, q.size() != 2);
        check("in_rdy_n", rdy_n, q.size() != 2);
        check("out_vld_b", vld_b, q.size() != 0);
        check("out_vld_n", vld_n, q.size() != 0);
        if (q.size() != 0) begin
            check("result_b", res_b, q[0].rb);
            check("result_n", res_n, q[0].rn);
            check("fflags_b", ff_b, q[0].fl);
            check("fflags_n", ff_n, q[0].fl);
        end
    endtask

    task automatic tick();
        logic        push, pop;
        logic [68:0] r;
        exp_t        e;
        push = in_vld && q.size() != 2 && !rst;
        pop  = out_rdy && q.size() != 0 && !rst;
        r = ref_pack(in_double, in_single, in_sign, in_class, in_rm,
                     in_expn, in_frac, in_flags, 1'b1);
        e.rb = r[68:5];
        e.fl = r[4:0];
        r = ref_pack(in_double, in_single, in_sign, in_class, in_rm,
                     in_expn, in_frac, in_flags, 1'b0);
        e.rn = r[68:5];
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
        observe();
    endtask

    task automatic set_req(input logic dbl, input logic sgl,
                           input logic s, input logic [2:0] cls,
                           input logic [10:0] e, input logic [51:0] f,
                           input logic [2:0] rm, input logic [4:0] fl);
        in_vld    = 1'b1;
        in_double = dbl;
        in_single = sgl;
        in_sign   = s;
        in_class  = cls;
        in_expn   = e;
        in_frac   = f;
        in_rm     = rm;
        in_flags  = fl;
    endtask

    task automatic rand_req();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        set_req($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                11'($urandom), t[51:0],
                ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                            : 3'($urandom_range(0, 4)),
                5'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        out_rdy = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 52'd0, 3'd0, 5'd0);
        in_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_result", res_b, 64'd0);
        check("rst_fflags", ff_b, 64'd0);

        out_rdy = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 3'd0, 11'h080, 52'h1, 3'd0, 5'd0);
        tick();
        in_vld = 1'b0;
        check("s_norm_res", res_b, 64'hFFFF_FFFF_C000_0001);
        check("s_norm_ff", ff_b, 64'd0);
        tick();

        set_req(1'b1, 1'b0, 1'b0, 3'd4, 11'd0, 52'd0, 3'd2, 5'd0);
        tick();
        in_vld = 1'b0;
        check("ovf_rdn_p", res_b, 64'h7FEF_FFFF_FFFF_FFFF);
        check("ovf_rdn_p_ff", ff_b, 64'h05);
        tick();
        set_req(1'b1, 1'b0, 1'b1, 3'd4, 11'd0, 52'd0, 3'd2, 5'd0);
        tick();
        in_vld = 1'b0;
        check("ovf_rdn_n", res_b, 64'hFFF0_0000_0000_0000);
        check("ovf_rdn_n_ff", ff_b, 64'h05);
        tick();

        set_req(1'b0, 1'b1, 1'b1, 3'd3, 11'd0, 52'd0, 3'd0, 5'b10000);
        tick();
        in_vld = 1'b0;
        check("qnan_box", res_b, 64'hFFFF_FFFF_7FC0_0000);
        check("qnan_nobox", res_n, 64'h0000_0000_7FC0_0000);
        check("qnan_ff", ff_b, 64'h10);
        tick();

        out_rdy = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 11'h400, 52'h1, 3'd0, 5'd0);
        tick();
        set_req(1'b1, 1'b0, 1'b1, 3'd0, 11'h400, 52'h8_0000_0000_0000,
                3'd0, 5'd1);
        tick();
        in_vld = 1'b0;
        check("bp_full", rdy_b, 64'd0);
        check("bp_head", res_b, 64'h4000_0000_0000_0001);
        tick();
        check("bp_hold", res_b, 64'h4000_0000_0000_0001);
        out_rdy = 1'b1;
        tick();
        check("bp_second", res_b, 64'hC008_0000_0000_0000);
        check("bp_rdy", rdy_b, 64'd1);
        tick();
        check("bp_empty", vld_b, 64'd0);

        rand_req();
        tick();
        for (int i = 0; i < 7; i++) begin
            rand_req();
            tick();
            check("stream_vld", vld_b, 64'd1);
            check("stream_rdy", rdy_b, 64'd1);
        end
        in_vld = 1'b0;
        tick();

        out_rdy = 1'b0;
        rand_req();
        tick();
        rand_req();
        tick();
        check("pre_rst_full", rdy_b, 64'd0);
        in_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_vld", vld_b, 64'd0);
        check("post_rst_rdy", rdy_b, 64'd1);
        check("post_rst_res", res_b, 64'd0);
        check("post_rst_ff", ff_b, 64'd0);
        out_rdy = 1'b1;
        tick();
        rand_req();
        tick();
        in_vld = 1'b0;
        tick();

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) < 7) rand_req();
            else in_vld = 1'b0;
            out_rdy = $urandom_range(0, 9) < 6;
            tick();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
